// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_sequencer block: opcode map, sequencer
// state encoding and ALU operation select.
package cpu_pkg;

  // Instruction opcodes as presented by the instruction memory.
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_NOP1 = 3'b101;
  localparam logic [2:0] OP_NOP2 = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // ALU operation select; matches the low two opcode bits of ALU-class ops.
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } seq_state_t;

  // ALU class is every opcode with the top bit clear.
  function automatic logic is_alu(input logic [2:0] op);
    return ~op[2];
  endfunction

  // Instructions that advance the PC by one in WB.
  function automatic logic is_seq(input logic [2:0] op);
    return is_alu(op) || (op == OP_NOP1) || (op == OP_NOP2);
  endfunction

  function automatic alu_op_t alu_sel(input logic [2:0] op);
    return alu_op_t'(op[1:0]);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Count register: clear first, otherwise increment unless saturated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      count <= '0;
    else if (clr)                  count <= '0;
    else if (inc && (count != '1)) count <= count + 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit datapath. Steps each
// instruction through FETCH/DECODE/EXEC/WB and drives the PC, register file
// and ALU enables. Outputs are decoded from registered state and the latched
// opcode only, so the instruction-memory output never reaches them directly.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int MAX_INSTR   = 1000,
  parameter int STOP_ON_OVF = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step_mode,
  input  logic                 clear,
  input  logic [2:0]           opcode,
  input  logic                 overflow_flag,
  output logic                 ir_en,
  output logic                 alu_en,
  output logic [1:0]           alu_op,
  output logic                 result_we,
  output logic                 pc_en,
  output logic                 pc_load,
  output logic                 busy,
  output logic                 halted,
  output logic                 timeout,
  output logic                 ovf_stop,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INSTR);

  seq_state_t           state, state_nx;
  logic [2:0]           op_q;
  logic                 step_q;
  logic                 timeout_q, ovf_q;
  logic                 retire, cnt_clr;
  logic                 set_to, set_ovf;
  logic                 ovf_hit, wdog_hit;
  logic [CNT_WIDTH-1:0] cnt_upd;

  // Retired-instruction counter.
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .clr   (cnt_clr),
    .count (instr_count)
  );

  // Count value after the retire happening this cycle (saturating), used so
  // the watchdog fires on the instruction that reaches the limit.
  assign cnt_upd  = (instr_count == '1) ? instr_count : instr_count + 1'b1;
  assign wdog_hit = (cnt_upd == MAX_CNT);
  // Overflow stop only matters for ALU ops; JMP retires in EXEC and is never
  // ALU class, so this term is safe to share between EXEC and WB.
  assign ovf_hit  = (STOP_ON_OVF != 0) && is_alu(op_q) && overflow_flag;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Latched run mode, decoded opcode and sticky halt causes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= OP_ADD;
      step_q    <= 1'b0;
      timeout_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (state == S_IDLE && start) step_q <= step_mode;
      if (state == S_DECODE)        op_q   <= opcode;
      if (cnt_clr) begin
        timeout_q <= 1'b0;
        ovf_q     <= 1'b0;
      end else begin
        if (set_to)  timeout_q <= 1'b1;
        if (set_ovf) ovf_q     <= 1'b1;
      end
    end
  end

  // Next-state: sequencing, retire and the post-retire stop priority.
  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    set_to   = 1'b0;
    set_ovf  = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        if (op_q == OP_HALT) begin
          retire   = 1'b1;
          state_nx = S_HALT;
        end else if (op_q == OP_JMP) begin
          retire = 1'b1;
          if (wdog_hit) begin
            state_nx = S_HALT;
            set_to   = 1'b1;
          end else if (step_q) begin
            state_nx = S_IDLE;
          end else begin
            state_nx = S_FETCH;
          end
        end else begin
          state_nx = S_WB;
        end
      end
      S_WB: begin
        retire = 1'b1;
        if (ovf_hit) begin
          state_nx = S_HALT;
          set_ovf  = 1'b1;
        end else if (wdog_hit) begin
          state_nx = S_HALT;
          set_to   = 1'b1;
        end else if (step_q) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_FETCH;
        end
      end
      S_HALT: begin
        // clear wins; a start arriving with it is simply not looked at here.
        if (clear) begin
          state_nx = S_IDLE;
          cnt_clr  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath controls decoded from state and latched opcode.
  always_comb begin
    ir_en     = 1'b0;
    alu_en    = 1'b0;
    alu_op    = 2'b00;
    result_we = 1'b0;
    pc_en     = 1'b0;
    pc_load   = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    unique case (state)
      S_FETCH: begin
        busy  = 1'b1;
        ir_en = 1'b1;
      end
      S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy = 1'b1;
        if (is_alu(op_q)) begin
          alu_en = 1'b1;
          alu_op = alu_sel(op_q);
        end
        if (op_q == OP_JMP) pc_load = 1'b1;
      end
      S_WB: begin
        busy = 1'b1;
        if (is_alu(op_q)) begin
          alu_en    = 1'b1;
          alu_op    = alu_sel(op_q);
          result_we = 1'b1;
        end
        if (is_seq(op_q)) pc_en = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign timeout  = timeout_q;
  assign ovf_stop = ovf_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized scoreboard bench for cpu_sequencer. A reference model walks the
// program at instruction level when each start is issued and queues the
// expected control pulses and end-of-run status; a monitor pops and compares.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int CW   = 5;
  localparam int MAXI = 25;

  localparam int EV_RES  = 0;
  localparam int EV_PCEN = 1;
  localparam int EV_PCLD = 2;
  localparam int EV_HALT = 3;
  localparam int EV_IDLE = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, step_mode = 1'b0, clear = 1'b0;
  logic [2:0]    opcode;
  logic          overflow_flag;
  logic          ir_en, alu_en, result_we, pc_en, pc_load, busy, halted, timeout, ovf_stop;
  logic [1:0]    alu_op;
  logic [CW-1:0] instr_count;

  cpu_sequencer #(.CNT_WIDTH(CW), .MAX_INSTR(MAXI), .STOP_ON_OVF(1)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .clear(clear),
    .opcode(opcode), .overflow_flag(overflow_flag), .ir_en(ir_en), .alu_en(alu_en),
    .alu_op(alu_op), .result_we(result_we), .pc_en(pc_en), .pc_load(pc_load),
    .busy(busy), .halted(halted), .timeout(timeout), .ovf_stop(ovf_stop),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment datapath: program memory, overflow flags, jump targets, PC.
  logic [2:0] imem [64];
  logic       ovf_mem [64];
  logic [5:0] jt [64];
  logic [5:0] pc;

  always @(posedge clk or negedge rst) begin
    if (!rst)         pc <= 6'd0;
    else if (pc_load) pc <= jt[pc];
    else if (pc_en)   pc <= pc + 6'd1;
  end
  assign opcode        = imem[pc];
  assign overflow_flag = ovf_mem[pc];

  typedef struct {
    int         kind;
    int         cyc;
    logic [1:0] aop;
    int         cnt;
    logic       to;
    logic       ov;
  } ev_t;

  ev_t expq[$];
  int  vectors = 0, miscompares = 0;

  // Reference model state (instruction level).
  int         mcnt = 0;
  logic [5:0] mpc = 6'd0;
  logic       mto = 1'b0, movf = 1'b0, mhalt = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input logic [1:0] aop);
    ev_t e;
    e.kind = kind; e.cyc = c; e.aop = aop; e.cnt = mcnt; e.to = mto; e.ov = movf;
    expq.push_back(e);
  endtask

  function automatic int sat_inc(input int c);
    return (c == (1 << CW) - 1) ? c : c + 1;
  endfunction

  // Walk the program from mpc starting with a FETCH at fetch_cyc.
  // ALU/NOP take 4 cycles (WB pulses on the 4th), JMP 3 (pc_load on the 3rd),
  // HALT opcode lands in HALT 3 cycles after its FETCH.
  task automatic model_run(input int fetch_cyc, input bit step);
    int t, nt, n;
    bit done, ovf_hit;
    logic [2:0] op;
    t = fetch_cyc; done = 0; n = 0;
    while (!done && n < 200) begin
      op = imem[mpc]; ovf_hit = 0; n++;
      if (op == OP_HALT) begin
        mcnt = sat_inc(mcnt); mhalt = 1;
        push_ev(EV_HALT, t + 3, 2'b00);
        done = 1;
      end else begin
        if (op == OP_JMP) begin
          push_ev(EV_PCLD, t + 2, 2'b00);
          mpc = jt[mpc]; nt = t + 3;
        end else begin
          if (op < 3'd4) begin
            push_ev(EV_RES, t + 3, op[1:0]);
            ovf_hit = ovf_mem[mpc];
          end
          push_ev(EV_PCEN, t + 3, 2'b00);
          mpc = mpc + 6'd1; nt = t + 4;
        end
        mcnt = sat_inc(mcnt);
        if (ovf_hit)            begin movf = 1; mhalt = 1; push_ev(EV_HALT, nt, 2'b00); done = 1; end
        else if (mcnt == MAXI)  begin mto = 1; mhalt = 1; push_ev(EV_HALT, nt, 2'b00); done = 1; end
        else if (step)          begin push_ev(EV_IDLE, nt, 2'b00); done = 1; end
        else t = nt;
      end
    end
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (expq.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, expected none", kind, cyc);
      return;
    end
    e = expq.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_cycle", cyc, e.cyc);
    if (e.kind == EV_RES) begin
      chk("alu_op", alu_op, e.aop);
      chk("alu_en_in_wb", alu_en, 1);
    end
    if (e.kind == EV_HALT || e.kind == EV_IDLE) begin
      chk("instr_count", instr_count, e.cnt);
      chk("timeout", timeout, e.to);
      chk("ovf_stop", ovf_stop, e.ov);
      chk("busy_at_stop", busy, 0);
    end
  endtask

  // Monitor: sample mid-cycle, turn pulses and state edges into events.
  initial begin
    bit pb, ph;
    pb = 0; ph = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pb = 0; ph = 0;
      end else begin
        if (pc_en && pc_load) chk("pc_en_pc_load_exclusive", 1, 0);
        if (result_we)        observe(EV_RES);
        if (pc_en)            observe(EV_PCEN);
        if (pc_load)          observe(EV_PCLD);
        if (halted && !ph)    observe(EV_HALT);
        if (pb && !busy && !halted) observe(EV_IDLE);
        pb = busy; ph = halted;
      end
    end
  end

  task automatic gen_prog();
    int p;
    for (int i = 0; i < 64; i++) begin
      p = $urandom_range(0, 99);
      if (p < 50)      imem[i] = 3'($urandom_range(0, 3));
      else if (p < 59) imem[i] = OP_NOP1;
      else if (p < 68) imem[i] = OP_NOP2;
      else if (p < 85) imem[i] = OP_JMP;
      else             imem[i] = OP_HALT;
      ovf_mem[i] = ($urandom_range(0, 9) == 0);
      jt[i]      = 6'($urandom_range(0, 63));
    end
  endtask

  task automatic check_all_zero(input string name);
    chk(name, int'({ir_en, alu_en, alu_op, result_we, pc_en, pc_load, busy,
                    halted, timeout, ovf_stop}), 0);
    chk({name, "_count"}, instr_count, 0);
  endtask

  task automatic run_one(input bit step, input bit noise);
    int budget;
    @(posedge clk); #1;
    start = 1; step_mode = step;
    model_run(cyc + 1, step);
    @(posedge clk); #1;
    start = 0; step_mode = 1'($urandom_range(0, 1));
    budget = 0;
    while (expq.size() != 0 && budget < 400) begin
      // Stray start/clear while running must be ignored; kept off once only
      // the final HALT event remains so it cannot land in HALT.
      if (noise && !step && expq.size() > 1) begin
        start = 1'($urandom_range(0, 1));
        clear = 1'($urandom_range(0, 1));
      end else begin
        start = 0; clear = 0;
      end
      @(posedge clk); #1;
      budget++;
    end
    start = 0; clear = 0;
    if (expq.size() != 0) begin
      chk("run_completion_pending_events", expq.size(), 0);
      expq.delete();
    end
  endtask

  task automatic leave_halt();
    bit both;
    if ($urandom_range(0, 1) == 1) begin
      start = 1;
      @(posedge clk); #1;
      start = 0;
      chk("start_in_halt_ignored", halted, 1);
      chk("start_in_halt_busy", busy, 0);
    end
    both  = 1'($urandom_range(0, 1));
    clear = 1; start = both;
    @(posedge clk); #1;
    clear = 0; start = 0;
    mcnt = 0; mto = 0; movf = 0; mhalt = 0;
    chk("clear_halted", halted, 0);
    chk("clear_busy", busy, 0);
    chk("clear_count", instr_count, 0);
    chk("clear_timeout", timeout, 0);
    chk("clear_ovf_stop", ovf_stop, 0);
    if (both) begin
      @(posedge clk); #1;
      chk("clear_with_start_stays_idle", busy, 0);
    end
  endtask

  task automatic random_runs(input int n);
    for (int r = 0; r < n; r++) begin
      if (r % 5 == 0) gen_prog();
      run_one(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      if (mhalt) leave_halt();
    end
  endtask

  initial begin
    gen_prog();
    // Directed first program: ADD, SUB, HALT from address 0.
    imem[0] = OP_ADD; imem[1] = OP_SUB; imem[2] = OP_HALT;
    ovf_mem[0] = 0; ovf_mem[1] = 0; ovf_mem[2] = 0;

    #2 rst = 0;
    #1 check_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst = 1;

    run_one(0, 0);
    if (mhalt) leave_halt();

    random_runs(60);

    // Reset in the EXEC cycle of an ADD abandons it.
    for (int i = 0; i < 64; i++) begin imem[i] = OP_ADD; ovf_mem[i] = 0; end
    @(posedge clk); #1;
    start = 1; step_mode = 0;
    model_run(cyc + 1, 0);
    @(posedge clk); #1; start = 0;        // FETCH
    @(posedge clk);                       // DECODE
    @(posedge clk); #1;                   // EXEC
    chk("exec_alu_en_before_reset", alu_en, 1);
    #1 rst = 0;
    #1 check_all_zero("reset_mid_exec");
    expq.delete();
    mpc = 6'd0; mcnt = 0; mto = 0; movf = 0; mhalt = 0;
    @(posedge clk); #2 rst = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("after_reset_busy", busy, 0);
    chk("after_reset_halted", halted, 0);
    chk("after_reset_count", instr_count, 0);

    random_runs(15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
